// File: rtl/up_down_counter.sv
// up_down_counter: one-step up/down counter over MIN_COUNT..MAX_COUNT with wrap or saturate at the range ends
module up_down_counter #(
  parameter int WIDTH       = 4,
  parameter int MIN_COUNT   = 0,
  parameter int MAX_COUNT   = 2**WIDTH-1,
  parameter int RESET_VALUE = MIN_COUNT,
  parameter bit WRAP        = 1'b1
) (
  output logic [WIDTH-1:0] q,
  input  logic             choice,
  input  logic             clk,
  input  logic             reset
);
  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN_COUNT);
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] L_RST = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  assign q = r_count;
  always_comb begin
    w_next = choice ? (r_count < L_MAX ? r_count + L_ONE : (WRAP ? L_MIN : L_MAX))
                    : (r_count > L_MIN ? r_count - L_ONE : (WRAP ? L_MAX : L_MIN));
  end
  always_ff @(posedge clk) begin
    if (!reset) r_count <= L_RST;
    else        r_count <= w_next;
  end
endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter: scoreboard bench driving a wrapping and a saturating counter with the same directed vectors
module tb_up_down_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       choice = 1'b0;
  logic [3:0] q_wrap, q_sat;
  logic [7:0] sb[$];
  int checks = 0;
  int errors = 0;
  up_down_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (.q(q_wrap), .choice(choice), .clk(clk), .reset(reset));
  up_down_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat  (.q(q_sat),  .choice(choice), .clk(clk), .reset(reset));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic c, input logic r, input logic [3:0] ew, input logic [3:0] es);
    @(negedge clk);
    choice = c;
    reset = r;
    sb.push_back({ew, es});
  endtask
  task automatic run(input logic c, input int n, input logic [3:0] ew[], input logic [3:0] es[]);
    for (int i = 0; i < n; i++) step(c, 1'b1, ew[i], es[i]);
  endtask
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wrap_q", q_wrap, e[7:4]);
        check("sat_q", q_sat, e[3:0]);
      end
    end
  end
  initial begin
    step(1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0);
    run(1'b1, 5, '{1, 2, 3, 4, 5}, '{1, 2, 3, 4, 5});
    run(1'b1, 9, '{6, 7, 8, 9, 10, 11, 12, 13, 14}, '{6, 7, 8, 9, 10, 11, 12, 13, 14});
    run(1'b1, 3, '{15, 0, 1}, '{15, 15, 15});
    run(1'b0, 3, '{0, 15, 14}, '{14, 13, 12});
    run(1'b1, 9, '{15, 0, 1, 2, 3, 4, 5, 6, 7}, '{13, 14, 15, 15, 15, 15, 15, 15, 15});
    run(1'b0, 2, '{6, 5}, '{14, 13});
    run(1'b1, 4, '{6, 7, 8, 9}, '{14, 15, 15, 15});
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("wrap_hold_before_edge", q_wrap, 4'd9);
    check("sat_hold_before_edge", q_sat, 4'd15);
    sb.push_back({4'd0, 4'd0});
    step(1'b0, 1'b1, 4'd15, 4'd0);
    step(1'b0, 1'b1, 4'd14, 4'd0);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
